// File: rtl/alu_issue_ctrl_pkg.sv
// Shared opcodes, state encoding and widths for the ALU issue controller.
package alu_issue_ctrl_pkg;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned OPW  = 4;

  localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPW-1:0] OP_AND  = 4'b0010;
  localparam logic [OPW-1:0] OP_OR   = 4'b0011;
  localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPW-1:0] OP_SLL  = 4'b0101;
  localparam logic [OPW-1:0] OP_SRL  = 4'b0110;
  localparam logic [OPW-1:0] OP_SRA  = 4'b0111;
  localparam logic [OPW-1:0] OP_MUL  = 4'b1000;
  localparam logic [OPW-1:0] OP_MULH = 4'b1001;
  localparam logic [OPW-1:0] OP_DIV  = 4'b1010;
  localparam logic [OPW-1:0] OP_REM  = 4'b1011;
  localparam logic [OPW-1:0] OP_MULW = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_EXEC_HI = 2'd2
  } state_e;

  // Context carried from accept to retirement.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic          mulw;
    logic          trap;
  } ctx_t;

  // Trap on div/rem by zero or any opcode above MULW.
  function automatic logic trap_decode(input logic [OPW-1:0] oper, input logic [DW-1:0] b);
    logic illegal;
    logic divz;
    illegal = (oper > OP_MULW);
    divz    = ((oper == OP_DIV) || (oper == OP_REM)) && (b == '0);
    return illegal || divz;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake bus into the issue controller.
//  master: instruction source (drives cmd_*), slave: alu_issue_ctrl.
interface alu_issue_ctrl_if
  import alu_issue_ctrl_pkg::*;
;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_oper;
  logic [AW-1:0]  cmd_rd;
  logic [AW-1:0]  cmd_rs;
  logic [AW-1:0]  cmd_rt;
  logic           cmd_imm_sel;
  logic [DW-1:0]  cmd_imm;

  modport master (
    output cmd_valid, cmd_oper, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_oper, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: one write port, two combinational read ports, one debug read port.
//  clk/rst    clock, async active-high reset (all registers cleared)
//  we/waddr/wdata           write port
//  ra_a/rd_a, ra_b/rd_b     operand read ports
//  dbg_addr/dbg_data        debug read port
module alu_regfile
  import alu_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_a,
  output logic [DW-1:0] rd_a,
  input  logic [AW-1:0] ra_b,
  output logic [DW-1:0] rd_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    for (int i = 0; i < int'(NREG); i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= regs_d[i];
    end
  end

  assign rd_a     = regs_q[ra_a];
  assign rd_b     = regs_q[ra_b];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external 8-bit combinational ALU: accepts one instruction per
// handshake, reads operands from the local register file, drives the ALU, writes the
// result back. MULW runs two ALU passes (low then high half). Div/rem by zero and
// illegal opcodes retire with err and no writeback.
//  clk, rst           clock, async active-high reset
//  cmd                instruction handshake (slave side)
//  alu_a/b/oper       registered ALU inputs; alu_r/alu_zero ALU outputs
//  done, err          retirement pulse, trap indication
//  flag_z             zero flag of last successful writeback
//  dbg_addr/dbg_data  combinational register read for debug
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  alu_issue_ctrl_if.slave cmd,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_oper,
  input  logic [DW-1:0]  alu_r,
  input  logic           alu_zero,
  output logic           done,
  output logic           err,
  output logic           flag_z,
  input  logic [AW-1:0]  dbg_addr,
  output logic [DW-1:0]  dbg_data
);

  state_e         state_q, state_d;
  ctx_t           ctx_q, ctx_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_oper_q, alu_oper_d;
  logic           lo_zero_q, lo_zero_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           flag_z_q, flag_z_d;

  logic           rf_we;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rs_data, rt_data;
  logic [DW-1:0]  b_sel;

  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (alu_r),
    .ra_a     (cmd.cmd_rs),
    .rd_a     (rs_data),
    .ra_b     (cmd.cmd_rt),
    .rd_b     (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
  assign b_sel         = cmd.cmd_imm_sel ? cmd.cmd_imm : rt_data;

  // Next-state, operand capture, trap decode and writeback control.
  always_comb begin
    state_d    = state_q;
    ctx_d      = ctx_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_oper_d = alu_oper_q;
    lo_zero_d  = lo_zero_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    flag_z_d   = flag_z_q;
    rf_we      = 1'b0;
    rf_waddr   = ctx_q.rd;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          alu_a_d    = rs_data;
          alu_b_d    = b_sel;
          alu_oper_d = (cmd.cmd_oper == OP_MULW) ? OP_MUL : cmd.cmd_oper;
          ctx_d.rd   = cmd.cmd_rd;
          ctx_d.mulw = (cmd.cmd_oper == OP_MULW);
          ctx_d.trap = trap_decode(cmd.cmd_oper, b_sel);
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_we = !ctx_q.trap;
        if (ctx_q.mulw) begin
          // Flag deferred until both halves are known.
          lo_zero_d  = alu_zero;
          alu_oper_d = OP_MULH;
          state_d    = ST_EXEC_HI;
        end else begin
          if (!ctx_q.trap) flag_z_d = alu_zero;
          done_d  = 1'b1;
          err_d   = ctx_q.trap;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC_HI: begin
        rf_we    = 1'b1;
        rf_waddr = AW'(ctx_q.rd + AW'(1));
        flag_z_d = lo_zero_q && alu_zero;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ctx_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_oper_q <= '0;
      lo_zero_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flag_z_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctx_q      <= ctx_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_oper_q <= alu_oper_d;
      lo_zero_q  <= lo_zero_d;
      done_q     <= done_d;
      err_q      <= err_d;
      flag_z_q   <= flag_z_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_oper = alu_oper_q;
  assign done     = done_q;
  assign err      = err_q;
  assign flag_z   = flag_z_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with a behavioural 8-bit ALU.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    alu_a, alu_b, alu_r;
  logic [3:0]    alu_oper;
  logic          alu_zero;
  logic          done, err, flag_z;
  logic [1:0]    dbg_addr;
  logic [7:0]    dbg_data;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_oper (alu_oper),
    .alu_r    (alu_r),
    .alu_zero (alu_zero),
    .done     (done),
    .err      (err),
    .flag_z   (flag_z),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference combinational ALU.
  logic [15:0] prod;
  always_comb begin
    prod = 16'(alu_a) * 16'(alu_b);
    case (alu_oper)
      OP_ADD:  alu_r = alu_a + alu_b;
      OP_SUB:  alu_r = alu_a - alu_b;
      OP_AND:  alu_r = alu_a & alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      OP_XOR:  alu_r = alu_a ^ alu_b;
      OP_SLL:  alu_r = alu_a << alu_b;
      OP_SRL:  alu_r = alu_a >> alu_b;
      OP_SRA:  alu_r = 8'($signed(alu_a) >>> alu_b);
      OP_MUL:  alu_r = prod[7:0];
      OP_MULH: alu_r = prod[15:8];
      OP_DIV:  alu_r = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      OP_REM:  alu_r = (alu_b == 8'd0) ? alu_a : alu_a % alu_b;
      default: alu_r = 8'h00;
    endcase
    alu_zero = (alu_r == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  typedef struct {
    logic [3:0] oper;
    logic [1:0] rd, rs, rt;
    logic       imm_sel;
    logic [7:0] imm;
    int         lat;
    logic       err;
    logic       fz;
    logic [1:0] ca;
    logic [7:0] cv;
    logic [1:0] cb;
    logic [7:0] cbv;
  } vec_t;

  vec_t vt[14];

  // Issue one command, return edges from accept edge (=1) to the edge that raises done.
  task automatic run_cmd(input vec_t v, output int lat, output logic got_done, output logic got_err);
    bus.cmd_oper    = v.oper;
    bus.cmd_rd      = v.rd;
    bus.cmd_rs      = v.rs;
    bus.cmd_rt      = v.rt;
    bus.cmd_imm_sel = v.imm_sel;
    bus.cmd_imm     = v.imm;
    bus.cmd_valid   = 1'b1;
    got_done = 1'b0;
    got_err  = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    for (int n = 0; n < 8 && !got_done; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
      end
    end
  endtask

  initial begin
    int   lat;
    logic gd, ge;

    // Expected values hand-derived in sequence; register state carries between rows.
    vt[0]  = '{OP_ADD,  2'd1, 2'd1, 2'd0, 1'b1, 8'h05, 2, 1'b0, 1'b0, 2'd1, 8'h05, 2'd1, 8'h05};
    vt[1]  = '{OP_SUB,  2'd2, 2'd1, 2'd0, 1'b1, 8'h05, 2, 1'b0, 1'b1, 2'd2, 8'h00, 2'd1, 8'h05};
    vt[2]  = '{OP_ADD,  2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 2, 1'b0, 1'b0, 2'd2, 8'h01, 2'd1, 8'h05};
    vt[3]  = '{OP_ADD,  2'd0, 2'd0, 2'd0, 1'b1, 8'hC8, 2, 1'b0, 1'b0, 2'd0, 8'hC8, 2'd3, 8'h00};
    vt[4]  = '{OP_MULW, 2'd3, 2'd0, 2'd0, 1'b1, 8'hFA, 3, 1'b0, 1'b0, 2'd3, 8'h50, 2'd0, 8'hC3};
    vt[5]  = '{OP_SUB,  2'd2, 2'd2, 2'd0, 1'b1, 8'h01, 2, 1'b0, 1'b1, 2'd2, 8'h00, 2'd3, 8'h50};
    vt[6]  = '{OP_DIV,  2'd1, 2'd1, 2'd2, 1'b0, 8'h33, 2, 1'b1, 1'b1, 2'd1, 8'h05, 2'd2, 8'h00};
    vt[7]  = '{4'b1110, 2'd1, 2'd3, 2'd3, 1'b1, 8'h01, 2, 1'b1, 1'b1, 2'd1, 8'h05, 2'd3, 8'h50};
    vt[8]  = '{OP_REM,  2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 2, 1'b1, 1'b1, 2'd1, 8'h05, 2'd0, 8'hC3};
    vt[9]  = '{OP_DIV,  2'd1, 2'd3, 2'd0, 1'b1, 8'h08, 2, 1'b0, 1'b0, 2'd1, 8'h0A, 2'd3, 8'h50};
    vt[10] = '{OP_REM,  2'd2, 2'd3, 2'd0, 1'b1, 8'h07, 2, 1'b0, 1'b0, 2'd2, 8'h03, 2'd1, 8'h0A};
    vt[11] = '{OP_MULW, 2'd1, 2'd1, 2'd1, 1'b0, 8'hEE, 3, 1'b0, 1'b0, 2'd1, 8'h64, 2'd2, 8'h00};
    vt[12] = '{OP_MULW, 2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 3, 1'b0, 1'b1, 2'd2, 8'h00, 2'd3, 8'h00};
    vt[13] = '{OP_XOR,  2'd0, 2'd0, 2'd0, 1'b0, 8'h77, 2, 1'b0, 1'b1, 2'd0, 8'h00, 2'd1, 8'h64};

    // Reset with cmd_valid asserted: must not be accepted.
    rst = 1'b1;
    dbg_addr = 2'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_oper = OP_ADD; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0; bus.cmd_rt = 2'd0;
    bus.cmd_imm_sel = 1'b1; bus.cmd_imm = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_flag_z", 32'(flag_z), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_b", 32'(alu_b), 32'd0);
    chk("reset_alu_oper", 32'(alu_oper), 32'd0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("reset_r%0d", r), 2'(r), 8'h00);

    // Table-driven single commands.
    for (int i = 0; i < 14; i++) begin
      run_cmd(vt[i], lat, gd, ge);
      chk($sformatf("v%0d_done", i), 32'(gd), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_err", i), 32'(ge), 32'(vt[i].err));
      chk($sformatf("v%0d_flag_z", i), 32'(flag_z), 32'(vt[i].fz));
      chk_reg($sformatf("v%0d_reg_a", i), vt[i].ca, vt[i].cv);
      chk_reg($sformatf("v%0d_reg_b", i), vt[i].cb, vt[i].cbv);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // Back-to-back: three ADD r0 += 1 with valid held high; r0 starts at 0.
    bus.cmd_oper = OP_ADD; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0;
    bus.cmd_imm_sel = 1'b1; bus.cmd_imm = 8'h01;
    bus.cmd_valid = 1'b1;
    dbg_addr = 2'd0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) bus.cmd_valid = 1'b0;
      chk($sformatf("b2b_ready_%0d", k), 32'(bus.cmd_ready), 32'((k % 2) == 0));
      chk($sformatf("b2b_done_%0d", k), 32'(done), 32'((k % 2) == 0));
      chk($sformatf("b2b_r0_%0d", k), 32'(dbg_data), 32'(k / 2));
    end
    chk("b2b_flag_z", 32'(flag_z), 32'd0);

    // Command presented while busy must be ignored.
    bus.cmd_oper = OP_ADD; bus.cmd_rd = 2'd3; bus.cmd_rs = 2'd0; bus.cmd_imm = 8'h10;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_rd = 2'd2; bus.cmd_imm = 8'h20;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    chk("busy_done", 32'(done), 32'd1);
    chk_reg("busy_r3", 2'd3, 8'h13);
    chk_reg("busy_r2", 2'd2, 8'h00);

    // Reset during EXEC_HI of a MULW: no retirement, everything cleared.
    bus.cmd_oper = OP_MULW; bus.cmd_rd = 2'd1; bus.cmd_rs = 2'd1;
    bus.cmd_imm_sel = 1'b1; bus.cmd_imm = 8'h02;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_mulw_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    gd = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      if (done) gd = 1'b1;
    end
    chk("abort_no_done", 32'(gd), 32'd0);
    chk("abort_flag_z", 32'(flag_z), 32'd0);
    for (int r = 0; r < 4; r++) chk_reg($sformatf("abort_r%0d", r), 2'(r), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
